// File: rtl/cpu_prefetch.sv
// Pipelined instruction prefetcher: issues Wishbone reads ahead and queues tagged words for decode.
// Latency: request issued the cycle after reset/restart, ack in cycle N -> instr_valid_o in N+1; backpressure via credit (outstanding + queued < Depth).
module cpu_prefetch #(
    parameter int          Depth     = 4,
    parameter logic [29:0] ResetAddr = 30'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_i,
    input  logic [29:0] redirect_addr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [29:0] instr_pc_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i,
    input  logic [31:0] bus_data_s,
    input  logic        bus_ack,
    input  logic        bus_stall,
    input  logic        bus_err,
    output logic [31:0] bus_data_m,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we
);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {FETCH, HALT, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [29:0]    fetch_addr_q, fetch_addr_d;
    logic [29:0]    resp_pc_q, resp_pc_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    data_q [Depth];
    logic [31:0]    data_d [Depth];
    logic [29:0]    pc_q   [Depth];
    logic [29:0]    pc_d   [Depth];
    logic           err_q  [Depth];
    logic           err_d  [Depth];

    logic credit, stb, accept, resp, push, pop;

    // Counting in-flight requests against queue space guarantees every response has a slot.
    assign credit = ({1'b0, outst_q} + {1'b0, count_q}) < (CW+1)'(Depth);
    assign stb    = reset_n && (state_q == FETCH) && credit;
    assign accept = stb && !bus_stall;
    assign resp   = (bus_ack || bus_err) && (outst_q != '0);
    assign push   = resp && (state_q == FETCH) && !redirect_i;
    assign pop    = instr_ready_i && (count_q != '0) && !redirect_i;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        resp_pc_d    = resp_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        data_d       = data_q;
        pc_d         = pc_q;
        err_d        = err_q;
        outst_d      = outst_q + CW'(accept) - CW'(resp);
        count_d      = count_q + CW'(push) - CW'(pop);

        if (accept) begin
            fetch_addr_d = fetch_addr_q + 30'd1;
        end
        if (push) begin
            data_d[wr_ptr_q] = bus_err ? 32'h0 : bus_data_s;
            pc_d[wr_ptr_q]   = resp_pc_q;
            err_d[wr_ptr_q]  = bus_err;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            resp_pc_d        = resp_pc_q + 30'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            FETCH:   if (push && bus_err) state_d = HALT;
            DRAIN:   if (outst_d == '0) state_d = FETCH;
            default: state_d = state_q;
        endcase

        // Responses still in flight at a redirect belong to the abandoned stream.
        if (redirect_i) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fetch_addr_d = redirect_addr_i;
            resp_pc_d    = redirect_addr_i;
            state_d      = (outst_d == '0) ? FETCH : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            fetch_addr_q <= ResetAddr;
            resp_pc_q    <= ResetAddr;
            outst_q      <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            data_q       <= data_d;
            pc_q         <= pc_d;
            err_q        <= err_d;
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = data_q[rd_ptr_q];
    assign instr_pc_o    = pc_q[rd_ptr_q];
    assign instr_err_o   = err_q[rd_ptr_q];

    assign bus_data_m = 32'h0;
    assign bus_addr   = fetch_addr_q;
    assign bus_sel    = 4'hF;
    assign bus_we     = 1'b0;
    assign bus_stb    = stb;
    assign bus_cyc    = stb || (outst_q != '0);
endmodule

// File: tb/tb_cpu_prefetch.sv
// Bench for cpu_prefetch: pipelined Wishbone slave model plus an in-order scoreboard of expected fetch outputs.
module tb_cpu_prefetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [29:0] redirect_addr_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [29:0] instr_pc_o;
    logic        instr_err_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] bus_data_s = '0;
    logic        bus_ack = 1'b0;
    logic        bus_stall = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_data_m;
    logic [29:0] bus_addr;
    logic [3:0]  bus_sel;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;

    cpu_prefetch #(.Depth(4), .ResetAddr(30'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_err_o(instr_err_o), .instr_ready_i(instr_ready_i),
        .bus_data_s(bus_data_s), .bus_ack(bus_ack), .bus_stall(bus_stall), .bus_err(bus_err),
        .bus_data_m(bus_data_m), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we)
    );

    always #5 clk = ~clk;

    typedef struct { logic [29:0] addr; int epoch; } req_t;
    typedef struct { logic [29:0] pc; logic [31:0] data; logic err; } exp_t;

    req_t        pending[$];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          epoch = 0;
    int          acc_since = 0;
    int          n_pop = 0;
    logic        halted_m = 1'b0;
    logic        err_seen = 1'b0;
    logic [29:0] exp_fetch = 30'h0;
    logic        ack_en = 1'b0;
    logic        err_en = 1'b0;
    logic [29:0] err_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {2'b01, a} ^ 32'hA5A5_0F0F;
    endfunction

    // Monitor first, then slave response, then request acceptance, all ahead of the next rising edge.
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        if (!reset_n) begin
            pending.delete();
            sb.delete();
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_data_s = '0;
            epoch++;
            exp_fetch = 30'h0;
            halted_m  = 1'b0;
        end else begin
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", {34'h0, instr_pc_o}, 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("head_pc", {34'h0, instr_pc_o}, {34'h0, e.pc});
                    check("head_data", {32'h0, instr_o}, {32'h0, e.data});
                    check("head_err", {63'h0, instr_err_o}, {63'h0, e.err});
                    if (e.err) err_seen = 1'b1;
                    n_pop++;
                end
            end
            bus_ack = 1'b0;
            bus_err = 1'b0;
            bus_data_s = '0;
            if (ack_en && pending.size() > 0) begin
                r = pending.pop_front();
                if (err_en && r.addr == err_addr) begin
                    bus_err = 1'b1;
                    bus_data_s = 32'hDEAD_BEEF;
                end else begin
                    bus_ack = 1'b1;
                    bus_data_s = word_of(r.addr);
                end
                if (r.epoch == epoch && !redirect_i && !halted_m) begin
                    e.pc   = r.addr;
                    e.err  = bus_err;
                    e.data = bus_err ? 32'h0 : word_of(r.addr);
                    sb.push_back(e);
                    if (bus_err) halted_m = 1'b1;
                end
            end
            if (bus_stb && !bus_stall) begin
                check("req_addr", {34'h0, bus_addr}, {34'h0, exp_fetch});
                exp_fetch = exp_fetch + 30'd1;
                r.addr  = bus_addr;
                r.epoch = epoch;
                pending.push_back(r);
                acc_since++;
            end
            if (redirect_i) begin
                sb.delete();
                epoch++;
                exp_fetch = redirect_addr_i;
                halted_m  = 1'b0;
                acc_since = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic redirect_to(input logic [29:0] a);
        redirect_i = 1'b1;
        redirect_addr_i = a;
        tick(1);
        redirect_i = 1'b0;
    endtask

    task automatic wait_valid_pc(input string tag, input logic [29:0] pc);
        for (int i = 0; i < 60 && !instr_valid_o; i++) tick(1);
        check({tag, "_valid"}, {63'h0, instr_valid_o}, 64'h1);
        check({tag, "_pc"}, {34'h0, instr_pc_o}, {34'h0, pc});
    endtask

    initial begin
        int p0;
        tick(2);
        check("rst_cyc", {63'h0, bus_cyc}, 64'h0);
        check("rst_stb", {63'h0, bus_stb}, 64'h0);
        check("rst_valid", {63'h0, instr_valid_o}, 64'h0);
        check("rst_addr", {34'h0, bus_addr}, 64'h0);
        check("rst_data", {32'h0, instr_o}, 64'h0);
        check("rst_pc_err", {33'h0, instr_pc_o, instr_err_o}, 64'h0);
        check("const_outs", {27'h0, bus_data_m, bus_sel, bus_we}, {27'h0, 32'h0, 4'hF, 1'b0});

        // Streaming: one word per cycle, first word visible two cycles after reset release.
        ack_en = 1'b1;
        instr_ready_i = 1'b1;
        reset_n = 1'b1;
        tick(1);
        check("stream_c1_valid", {63'h0, instr_valid_o}, 64'h0);
        tick(1);
        check("stream_c2_valid", {63'h0, instr_valid_o}, 64'h1);
        check("stream_c2_pc", {34'h0, instr_pc_o}, 64'h0);
        tick(4);
        p0 = n_pop;
        tick(10);
        check("throughput", 64'(n_pop - p0), 64'd10);

        // Credit limit with consumer stalled; redirect also flushes the queued words.
        instr_ready_i = 1'b0;
        redirect_to(30'h40);
        check("flush_valid", {63'h0, instr_valid_o}, 64'h0);
        tick(12);
        check("credit_accepts", 64'(acc_since), 64'd4);
        check("credit_stb", {63'h0, bus_stb}, 64'h0);
        check("credit_head", {34'h0, instr_pc_o}, 64'h40);
        instr_ready_i = 1'b1;
        tick(1);
        instr_ready_i = 1'b0;
        check("credit_reopen", {63'h0, bus_stb}, 64'h1);
        tick(4);
        check("credit_accepts2", 64'(acc_since), 64'd5);
        check("credit_stb2", {63'h0, bus_stb}, 64'h0);

        // Stall holds the request address steady.
        bus_stall = 1'b1;
        instr_ready_i = 1'b1;
        redirect_to(30'h5);
        for (int i = 0; i < 3; i++) begin
            check("stall_addr", {34'h0, bus_addr}, 64'h5);
            check("stall_stb", {63'h0, bus_stb}, 64'h1);
            tick(1);
        end
        check("stall_no_accept", 64'(acc_since), 64'd0);
        bus_stall = 1'b0;
        tick(1);
        check("stall_release", 64'(acc_since), 64'd1);
        check("stall_next_addr", {34'h0, bus_addr}, 64'h6);
        tick(5);

        // Redirect with three requests in flight: their acks must be discarded.
        ack_en = 1'b0;
        for (int i = 0; i < 20 && pending.size() != 3; i++) tick(1);
        check("three_outstanding", 64'(pending.size()), 64'd3);
        ack_en = 1'b1;
        redirect_to(30'h100);
        check("drain_valid", {63'h0, instr_valid_o}, 64'h0);
        check("drain_stb", {63'h0, bus_stb}, 64'h0);
        wait_valid_pc("redir", 30'h100);
        tick(5);

        // Bus error halts fetch until a redirect.
        err_addr = 30'h7;
        err_en = 1'b1;
        err_seen = 1'b0;
        redirect_to(30'h3);
        for (int i = 0; i < 40 && !halted_m; i++) tick(1);
        check("halt_reached", {63'h0, halted_m}, 64'h1);
        tick(4);
        for (int i = 0; i < 5; i++) begin
            check("halt_stb", {63'h0, bus_stb}, 64'h0);
            tick(1);
        end
        check("halt_cyc", {63'h0, bus_cyc}, 64'h0);
        check("err_entry_seen", {63'h0, err_seen}, 64'h1);
        err_en = 1'b0;
        redirect_to(30'h20);
        wait_valid_pc("resume", 30'h20);
        tick(6);

        // Asynchronous reset in the middle of a burst.
        reset_n = 1'b0;
        #1;
        check("arst_cyc", {63'h0, bus_cyc}, 64'h0);
        check("arst_stb", {63'h0, bus_stb}, 64'h0);
        check("arst_valid", {63'h0, instr_valid_o}, 64'h0);
        tick(2);
        reset_n = 1'b1;
        check("arst_addr", {34'h0, bus_addr}, 64'h0);
        wait_valid_pc("restart", 30'h0);
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
